conbus_rr: RTL

CONBUS_RR -- requirements
Module: conbus_rr

---
 rtl/conbus_pkg.sv | 23 ++
 rtl/conbus_rr_arb.sv | 56 +++++
 rtl/conbus_rr.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/conbus_pkg.sv
// Shared Wishbone field widths, CTI codes and the address decode helper
// used by the round-robin shared-bus interconnect.
package conbus_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int CTI_W = 3;

    localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
    localparam logic [CTI_W-1:0] CTI_CONST   = 3'b001;
    localparam logic [CTI_W-1:0] CTI_INCR    = 3'b010;
    localparam logic [CTI_W-1:0] CTI_EOB     = 3'b111;

    function automatic logic addr_hit(
        input logic [ADR_W-1:0] adr,
        input logic [ADR_W-1:0] base,
        input logic [ADR_W-1:0] mask
    );
        return (adr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/conbus_rr_arb.sv
// Round-robin bus owner arbiter: holds the grant while the owner keeps
// cyc high, otherwise hands it to the next requester after the last owner.
module conbus_rr_arb
    import conbus_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last;
    logic [IW-1:0] last_next;
    logic [N-1:0]  gnt_next;
    logic          hold;

    assign hold = |(gnt & req);

    // Distance from last owner: the master just after it has offset 0.
    always_comb begin
        int off;
        int best;
        gnt_next  = '0;
        last_next = last;
        off       = 0;
        best      = N;
        if (hold) begin
            gnt_next = gnt;
        end else begin
            for (int j = 0; j < N; j++) begin
                off = (j + N - 1 - int'(last)) % N;
                if (req[j] && off < best) begin
                    best        = off;
                    gnt_next    = '0;
                    gnt_next[j] = 1'b1;
                    last_next   = IW'(j);
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gnt  <= '0;
            last <= IW'(N - 1);
        end else begin
            gnt  <= gnt_next;
            last <= last_next;
        end
    end

endmodule

// File: rtl/conbus_rr.sv
// Shared-bus Wishbone interconnect: one round-robin owner drives all
// slaves, address decode picks the target, unmapped/stall errors reported.
module conbus_rr
    import conbus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 6,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {N_SLAVES{32'hE0000000}},
    parameter int TIMEOUT   = 1024
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic [N_MASTERS*ADR_W-1:0]   m_adr_i,
    input  logic [N_MASTERS*DAT_W-1:0]   m_dat_i,
    input  logic [N_MASTERS*CTI_W-1:0]   m_cti_i,
    input  logic [N_MASTERS*SEL_W-1:0]   m_sel_i,
    input  logic [N_MASTERS-1:0]         m_we_i,
    input  logic [N_MASTERS-1:0]         m_cyc_i,
    input  logic [N_MASTERS-1:0]         m_stb_i,
    output logic [N_MASTERS*DAT_W-1:0]   m_dat_o,
    output logic [N_MASTERS-1:0]         m_ack_o,
    output logic [N_MASTERS-1:0]         m_err_o,
    output logic [N_SLAVES*ADR_W-1:0]    s_adr_o,
    output logic [N_SLAVES*DAT_W-1:0]    s_dat_o,
    output logic [N_SLAVES*CTI_W-1:0]    s_cti_o,
    output logic [N_SLAVES*SEL_W-1:0]    s_sel_o,
    output logic [N_SLAVES-1:0]          s_we_o,
    output logic [N_SLAVES-1:0]          s_cyc_o,
    output logic [N_SLAVES-1:0]          s_stb_o,
    input  logic [N_SLAVES*DAT_W-1:0]    s_dat_i,
    input  logic [N_SLAVES-1:0]          s_ack_i
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [N_MASTERS-1:0] gnt;
    logic [ADR_W-1:0]     own_adr;
    logic [DAT_W-1:0]     own_dat;
    logic [CTI_W-1:0]     own_cti;
    logic [SEL_W-1:0]     own_sel;
    logic                 own_we;
    logic                 own_cyc;
    logic                 own_stb;
    logic [N_SLAVES-1:0]  hit;
    logic [N_SLAVES-1:0]  sel_act;
    logic                 mapped;
    logic [DAT_W-1:0]     rdata;
    logic                 slave_ack;
    logic                 req_active;
    logic                 stall;
    logic                 wd_hit;
    logic                 wd_err;
    logic                 err_q;
    logic [CW-1:0]        cnt;

    conbus_rr_arb #(.N(N_MASTERS)) u_arb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (m_cyc_i),
        .gnt       (gnt)
    );

    // One-hot grant turns the owner mux into a plain OR.
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_cti = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (gnt[k]) begin
                own_adr = own_adr | m_adr_i[k*ADR_W +: ADR_W];
                own_dat = own_dat | m_dat_i[k*DAT_W +: DAT_W];
                own_cti = own_cti | m_cti_i[k*CTI_W +: CTI_W];
                own_sel = own_sel | m_sel_i[k*SEL_W +: SEL_W];
                own_we  = own_we  | m_we_i[k];
                own_cyc = own_cyc | m_cyc_i[k];
                own_stb = own_stb | m_stb_i[k];
            end
        end
    end

    always_comb begin
        hit    = '0;
        mapped = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!mapped && addr_hit(own_adr,
                                    SLAVE_BASE[i*32 +: 32],
                                    SLAVE_MASK[i*32 +: 32])) begin
                hit[i] = 1'b1;
                mapped = 1'b1;
            end
        end
    end

    assign sel_act = hit & {N_SLAVES{own_cyc}};

    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_act[i]) rdata = rdata | s_dat_i[i*DAT_W +: DAT_W];
        end
    end

    assign slave_ack  = |(s_ack_i & sel_act);
    assign req_active = own_cyc & own_stb;
    assign stall      = req_active & mapped & ~slave_ack;

    // Stb suppression must not depend on ack to avoid a slave comb loop.
    assign wd_hit = (TIMEOUT > 0) && req_active && mapped
                    && (cnt == CNT_MAX);
    assign wd_err = wd_hit & ~slave_ack;

    assign s_adr_o = {N_SLAVES{own_adr}};
    assign s_dat_o = {N_SLAVES{own_dat}};
    assign s_cti_o = {N_SLAVES{own_cti}};
    assign s_sel_o = {N_SLAVES{own_sel}};
    assign s_we_o  = {N_SLAVES{own_we}};
    assign s_cyc_o = sel_act;
    assign s_stb_o = sel_act & {N_SLAVES{own_stb & ~wd_hit}};

    assign m_dat_o = {N_MASTERS{rdata}};
    assign m_ack_o = gnt & {N_MASTERS{slave_ack}};
    assign m_err_o = gnt & {N_MASTERS{err_q | wd_err}};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= 1'b0;
            cnt   <= '0;
        end else begin
            err_q <= req_active & ~mapped & ~err_q;
            if (TIMEOUT == 0) begin
                cnt <= '0;
            end else if (stall && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
